tetromino_bag_queue: RTL

Successor to the single-lookahead piece generator. Produces the active tetromino plus a parametrised-depth preview queue, using either a 7-bag randomiser (every group of 7 consecutive pieces is a permutation of all 7 shapes) or the legacy pure-LFSR mode. It adds a runtime seed load and a valid/pop handshake. It sits between the game-control FSM, which pops a piece on spawn, and the board and preview renderers.

---
 rtl/tetromino_bag_queue_pkg.sv | 55 +++++
 rtl/tetromino_bag_queue_shape_rom.sv | 23 ++
 rtl/tetromino_bag_queue.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tetromino_bag_queue_pkg.sv
// Shared types, piece indices and rotation tables for the piece generator and renderers.
// Shapes are 4x4 bitmaps, bit 15 = row 0 col 0, one 16-bit word per rotation.
package tetromino_bag_queue_pkg;

   localparam int NUMBER_OF_TETROMINO = 7;

   localparam logic [2:0] TETROMINO_I     = 3'd0;
   localparam logic [2:0] TETROMINO_O     = 3'd1;
   localparam logic [2:0] TETROMINO_T     = 3'd2;
   localparam logic [2:0] TETROMINO_S     = 3'd3;
   localparam logic [2:0] TETROMINO_Z     = 3'd4;
   localparam logic [2:0] TETROMINO_J     = 3'd5;
   localparam logic [2:0] TETROMINO_L     = 3'd6;
   localparam logic [2:0] TETROMINO_EMPTY = 3'd7;

   typedef logic [3:0][15:0] tetromino_t;

   typedef struct packed {
      logic [3:0] x;
      logic [4:0] y;
   } coordinate_t;

   typedef struct packed {
      logic [2:0]  idx;
      tetromino_t  shape;
      logic [1:0]  rotation;
      coordinate_t coordinate;
   } tetromino_ctrl;

   // Rotation tables, listed as {rot3, rot2, rot1, rot0}.
   localparam tetromino_t SHAPE_I = {16'h4444, 16'h00F0, 16'h2222, 16'h0F00};
   localparam tetromino_t SHAPE_O = {16'h6600, 16'h6600, 16'h6600, 16'h6600};
   localparam tetromino_t SHAPE_T = {16'h4C40, 16'h0E40, 16'h4640, 16'h4E00};
   localparam tetromino_t SHAPE_S = {16'h8C40, 16'h06C0, 16'h4620, 16'h6C00};
   localparam tetromino_t SHAPE_Z = {16'h4C80, 16'h0C60, 16'h2640, 16'hC600};
   localparam tetromino_t SHAPE_J = {16'h44C0, 16'h0E20, 16'h6440, 16'h8E00};
   localparam tetromino_t SHAPE_L = {16'hC440, 16'h0E80, 16'h4460, 16'h2E00};

   typedef enum logic {
      FILL  = 1'b0,
      READY = 1'b1
   } bag_state_e;

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   // (a + b) mod 7 for piece indices already in 0..6.
   function automatic logic [2:0] wrap_add7(input logic [2:0] a, input logic [2:0] b);
      logic [3:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 4'(NUMBER_OF_TETROMINO)) ? 3'(s - 4'(NUMBER_OF_TETROMINO)) : s[2:0];
   endfunction

endpackage

// File: rtl/tetromino_bag_queue_shape_rom.sv
// Combinational shape lookup: piece index to all four rotations, zero for the empty slot.
module tetromino_shape_rom
   import tetromino_bag_queue_pkg::*;
(
   input  logic [2:0] idx_i,
   output tetromino_t shape_o
);

   always_comb begin
      shape_o = '0;
      case (idx_i)
         TETROMINO_I: shape_o = SHAPE_I;
         TETROMINO_O: shape_o = SHAPE_O;
         TETROMINO_T: shape_o = SHAPE_T;
         TETROMINO_S: shape_o = SHAPE_S;
         TETROMINO_Z: shape_o = SHAPE_Z;
         TETROMINO_J: shape_o = SHAPE_J;
         TETROMINO_L: shape_o = SHAPE_L;
         default:     shape_o = '0;
      endcase
   end

endmodule

// File: rtl/tetromino_bag_queue.sv
// Piece generator: LFSR-driven 7-bag (or plain LFSR) picks feeding a current piece plus
// preview queue, with runtime reseed and a valid/pop handshake toward the game controller.
module tetromino_bag_queue
   import tetromino_bag_queue_pkg::*;
#(
   parameter int          PREVIEW_DEPTH = 3,
   parameter bit          BAG_MODE      = 1'b1,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter int          SPAWN_X       = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         pop,
   input  logic                         seed_load,
   input  logic [15:0]                  seed,
   output logic                         valid,
   output tetromino_ctrl                t_out,
   output tetromino_ctrl                t_next_out,
   output logic [3*PREVIEW_DEPTH-1:0]   preview_idx
);

   localparam int         QLEN   = PREVIEW_DEPTH + 1;
   localparam logic [3:0] QLEN_C = 4'(QLEN);

   bag_state_e           state_q, state_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [6:0]           usedMask_q, usedMask_d;
   logic [QLEN-1:0][2:0] queue_q, queue_d;
   logic [3:0]           fillCount_q, fillCount_d;

   logic [2:0]           candidate;
   logic [2:0]           pick;
   logic [6:0]           pickedMask;
   logic [6:0]           nextMask;
   logic [2:0]           curIdx;
   logic [2:0]           nextIdx;
   tetromino_t           curShape;
   tetromino_t           nextShape;

   // Walk downward so the lowest offset from the candidate that is still free wins.
   always_comb begin
      candidate = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
      pick      = candidate;
      if (BAG_MODE) begin
         for (int k = 6; k >= 0; k--) begin
            if (!usedMask_q[wrap_add7(candidate, 3'(k))]) begin
               pick = wrap_add7(candidate, 3'(k));
            end
         end
      end
   end

   always_comb begin
      pickedMask = usedMask_q | (7'd1 << pick);
      nextMask   = '0;
      if (BAG_MODE && (pickedMask != 7'h7F)) begin
         nextMask = pickedMask;
      end
   end

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_step(lfsr_q);
      usedMask_d  = usedMask_q;
      queue_d     = queue_q;
      fillCount_d = fillCount_q;
      if (seed_load) begin
         state_d     = FILL;
         lfsr_d      = (seed == 16'h0000) ? LFSR_SEED : seed;
         usedMask_d  = '0;
         queue_d     = {QLEN{TETROMINO_EMPTY}};
         fillCount_d = '0;
      end else begin
         case (state_q)
            FILL: begin
               for (int i = 0; i < QLEN; i++) begin
                  if (4'(i) == fillCount_q) begin
                     queue_d[i] = pick;
                  end
               end
               fillCount_d = fillCount_q + 4'd1;
               usedMask_d  = nextMask;
               if (fillCount_d == QLEN_C) begin
                  state_d = READY;
               end
            end
            READY: begin
               if (pop) begin
                  for (int i = 0; i < QLEN - 1; i++) begin
                     queue_d[i] = queue_q[i+1];
                  end
                  queue_d[QLEN-1] = pick;
                  usedMask_d      = nextMask;
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL;
         lfsr_q      <= LFSR_SEED;
         usedMask_q  <= '0;
         queue_q     <= {QLEN{TETROMINO_EMPTY}};
         fillCount_q <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         usedMask_q  <= usedMask_d;
         queue_q     <= queue_d;
         fillCount_q <= fillCount_d;
      end
   end

   // Outputs decode registered state only, so pop never reaches them combinationally.
   assign valid       = (state_q == READY);
   assign curIdx      = valid ? queue_q[0] : TETROMINO_EMPTY;
   assign nextIdx     = valid ? queue_q[1] : TETROMINO_EMPTY;
   assign preview_idx = valid ? queue_q[QLEN-1:1] : {PREVIEW_DEPTH{TETROMINO_EMPTY}};

   tetromino_shape_rom u_cur_rom (
      .idx_i   (curIdx),
      .shape_o (curShape)
   );

   tetromino_shape_rom u_next_rom (
      .idx_i   (nextIdx),
      .shape_o (nextShape)
   );

   always_comb begin
      t_out              = '0;
      t_out.idx          = curIdx;
      t_out.shape        = curShape;
      t_out.rotation     = 2'd0;
      t_out.coordinate.x = 4'(SPAWN_X);
      t_out.coordinate.y = 5'd0;
      t_next_out              = '0;
      t_next_out.idx          = nextIdx;
      t_next_out.shape        = nextShape;
      t_next_out.rotation     = 2'd0;
      t_next_out.coordinate.x = 4'(SPAWN_X);
      t_next_out.coordinate.y = 5'd0;
   end

endmodule
